game_ctrl: RTL

GAME_CTRL -- requirements
Module: game_ctrl

---
 rtl/tetris_pkg.sv | 37 +++
 rtl/drop_timer.sv | 35 +++
 rtl/game_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/tetris_pkg.sv
// Shared game-controller codes: state and move encodings, board width, button bundle.
package tetris_pkg;

  localparam int BOARD_W = 32;
  localparam int LOC_W   = 5;

  typedef enum logic [2:0] {
    ST_GEN      = 3'd0,
    ST_MOVE     = 3'd1,
    ST_LAND     = 3'd2,
    ST_CLEAR    = 3'd3,
    ST_NEWBOARD = 3'd4,
    ST_GAMEOVER = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    MV_LEFT   = 2'd0,
    MV_RIGHT  = 2'd1,
    MV_ROTATE = 2'd2,
    MV_DROP   = 2'd3
  } move_t;

  typedef struct packed {
    logic rotate;
    logic left;
    logic right;
  } btn_req_t;

  // Rotate beats left beats right; no request means drop/idle.
  function automatic move_t req_to_move(input btn_req_t r);
    if (r.rotate)     return MV_ROTATE;
    else if (r.left)  return MV_LEFT;
    else if (r.right) return MV_RIGHT;
    else              return MV_DROP;
  endfunction

endpackage

// File: rtl/drop_timer.sv
// Gravity timer: counts MOVE cycles and raises a sticky pending flag on each wrap.
module drop_timer #(
  parameter int DROP_PERIOD = 16
) (
  input  logic clka,
  input  logic restart,
  input  logic clr,
  input  logic tick,
  input  logic consume,
  output logic pending
);

  localparam logic [7:0] LAST = 8'(DROP_PERIOD - 1);

  logic [7:0] cnt;
  logic       wrap;

  assign wrap = tick && (cnt == LAST);

  always_ff @(posedge clka or posedge restart) begin
    if (restart) begin
      cnt     <= '0;
      pending <= 1'b0;
    end else if (clr) begin
      cnt     <= '0;
      pending <= 1'b0;
    end else begin
      if (tick) cnt <= wrap ? 8'd0 : cnt + 8'd1;
      // A fresh wrap outranks consumption of the previous one.
      if (wrap)         pending <= 1'b1;
      else if (consume) pending <= 1'b0;
    end
  end

endmodule

// File: rtl/game_ctrl.sv
// Tetris game-flow controller: sequences spawn/move/land/clear and holds the game context.
// Optional GAME_CTRL_SCORE_EN adds a saturating 8-bit landed-piece score output.
module game_ctrl
  import tetris_pkg::*;
#(
  parameter int         DROP_PERIOD = 16,
  parameter logic [4:0] SPAWN_LO    = 5'd1,
  parameter logic [4:0] SPAWN_HI    = 5'd5
) (
  input  logic               clka,
  input  logic               restart,
  input  logic               btn_left,
  input  logic               btn_right,
  input  logic               btn_rotate,
  input  logic               start,
  input  logic [1:0]         dp_piece,
  input  logic [LOC_W-1:0]   dp_location,
  input  logic [1:0]         dp_rotation,
  input  logic               dp_touched,
  input  logic               dp_error,
  input  logic [BOARD_W-1:0] dp_board,
  output logic [2:0]         state,
  output logic [1:0]         move,
  output logic [LOC_W-1:0]   location,
  output logic [1:0]         rotation,
  output logic [1:0]         curr_piece,
  output logic [BOARD_W-1:0] board,
  output logic               game_over
`ifdef GAME_CTRL_SCORE_EN
  ,
  output logic [7:0]         score
`endif
);

  state_t   st, st_nxt;
  btn_req_t req;
  logic     in_move, btn_any, drop_pending, upd;
  move_t    mv;

  assign req     = '{rotate: btn_rotate, left: btn_left, right: btn_right};
  assign in_move = (st == ST_MOVE);
  assign btn_any = btn_rotate | btn_left | btn_right;

  drop_timer #(.DROP_PERIOD(DROP_PERIOD)) u_drop_timer (
    .clka    (clka),
    .restart (restart),
    .clr     (st == ST_GEN),
    .tick    (in_move),
    .consume (in_move && !btn_any),
    .pending (drop_pending)
  );

  // A landing cycle freezes position and reports an idle move.
  always_comb begin
    mv  = MV_DROP;
    upd = 1'b0;
    if (in_move && !dp_touched) begin
      mv  = req_to_move(req);
      upd = btn_any || drop_pending;
    end
  end

  always_comb begin
    st_nxt = ST_NEWBOARD;
    case (st)
      ST_NEWBOARD: st_nxt = ST_GEN;
      ST_GEN:      st_nxt = ST_MOVE;
      ST_MOVE:     st_nxt = dp_touched ? ST_LAND : ST_MOVE;
      ST_LAND:     st_nxt = ST_CLEAR;
      ST_CLEAR:    st_nxt = dp_error ? ST_GAMEOVER : ST_GEN;
      ST_GAMEOVER: st_nxt = start ? ST_NEWBOARD : ST_GAMEOVER;
      default:     st_nxt = ST_NEWBOARD;
    endcase
  end

  always_ff @(posedge clka or posedge restart) begin
    if (restart) st <= ST_NEWBOARD;
    else         st <= st_nxt;
  end

  always_ff @(posedge clka or posedge restart) begin
    if (restart) begin
      location   <= '0;
      rotation   <= '0;
      curr_piece <= '0;
      board      <= '0;
    end else begin
      case (st)
        ST_NEWBOARD: begin
          board    <= '0;
          location <= '0;
          rotation <= '0;
        end
        ST_GEN: begin
          curr_piece <= dp_piece;
          location   <= (dp_piece < 2'd2) ? SPAWN_LO : SPAWN_HI;
          rotation   <= '0;
        end
        ST_MOVE: begin
          if (upd) begin
            location <= dp_location;
            rotation <= dp_rotation;
          end
        end
        ST_LAND, ST_CLEAR: board <= dp_board;
        ST_GAMEOVER:       board <= '1;
        default: ;
      endcase
    end
  end

`ifdef GAME_CTRL_SCORE_EN
  always_ff @(posedge clka or posedge restart) begin
    if (restart)                            score <= '0;
    else if (st == ST_LAND && score != '1)  score <= score + 8'd1;
  end
`endif

  assign state     = st;
  assign move      = mv;
  assign game_over = (st == ST_GAMEOVER);

endmodule
